// File: rtl/dmem_responder_if.sv
// Data-memory request/response channel between the core LSU (master) and the
// memory-side responder (slave).
interface dmem_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                  ReqValid;
    logic                  ReqReady;
    logic                  ReqWr;
    logic [ADDR_WIDTH-1:0] ReqAddr;
    logic [2:0]            ReqFunct3;
    logic [DATA_WIDTH-1:0] ReqWrData;
    logic                  RspValid;
    logic                  RspReady;
    logic [DATA_WIDTH-1:0] RspRdData;
    logic                  RspErr;

    modport master (
        output ReqValid, ReqWr, ReqAddr, ReqFunct3, ReqWrData, RspReady,
        input  ReqReady, RspValid, RspRdData, RspErr
    );

    modport slave (
        input  ReqValid, ReqWr, ReqAddr, ReqFunct3, ReqWrData, RspReady,
        output ReqReady, RspValid, RspRdData, RspErr
    );
endinterface

// File: rtl/dmem_responder.sv
// Memory-side responder for RV32I loads/stores: one outstanding request, byte-strobed
// word RAM, sign/zero extension, fixed wait states before a held response.
module dmem_responder #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 512,
    parameter int WAIT_CYCLES = 2
) (
    input logic   Clk,
    input logic   ResetN,
    dmem_if.slave bus
);
    localparam int IDX_W = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t                r_state, w_state_nxt;
    logic [3:0]            r_cnt, w_cnt_nxt;
    logic                  r_rst_done;
    logic                  r_wr;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [2:0]            r_f3;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic                  r_err;
    logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

    logic                  w_req_ready, w_accept, w_enter_resp;
    logic                  w_wr;
    logic [ADDR_WIDTH-1:0] w_addr;
    logic [2:0]            w_f3;
    logic [DATA_WIDTH-1:0] w_wdata, w_wdata_rep, w_rword, w_ext;
    logic [1:0]            w_lane;
    logic [IDX_W-1:0]      w_idx;
    logic [3:0]            w_strb;
    logic [7:0]            w_byte;
    logic [15:0]           w_half;
    logic                  w_err_f3, w_mis, w_oor, w_err;

    assign w_req_ready  = r_rst_done && (r_state == IDLE);
    assign w_accept     = bus.ReqValid && w_req_ready;
    assign bus.ReqReady = w_req_ready;
    assign bus.RspValid = (r_state == RESP);
    assign bus.RspRdData = r_rdata;
    assign bus.RspErr   = r_err;

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_rst_done <= 1'b0;
            r_state    <= IDLE;
            r_cnt      <= '0;
        end else begin
            r_rst_done <= 1'b1;
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
        end
    end

    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_enter_resp = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    if (WAIT_CYCLES == 0) begin
                        w_state_nxt  = RESP;
                        w_enter_resp = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = 4'(WAIT_CYCLES - 1);
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt  = RESP;
                    w_enter_resp = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            RESP: begin
                if (bus.RspReady) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_wr    <= 1'b0;
            r_addr  <= '0;
            r_f3    <= '0;
            r_wdata <= '0;
        end else if (w_accept) begin
            r_wr    <= bus.ReqWr;
            r_addr  <= bus.ReqAddr;
            r_f3    <= bus.ReqFunct3;
            r_wdata <= bus.ReqWrData;
        end
    end

    // With zero wait states the RAM access happens on the accepting edge itself,
    // so in IDLE the live request is decoded instead of the captured copy.
    assign w_wr    = (r_state == IDLE) ? bus.ReqWr     : r_wr;
    assign w_addr  = (r_state == IDLE) ? bus.ReqAddr   : r_addr;
    assign w_f3    = (r_state == IDLE) ? bus.ReqFunct3 : r_f3;
    assign w_wdata = (r_state == IDLE) ? bus.ReqWrData : r_wdata;
    assign w_lane  = w_addr[1:0];
    assign w_idx   = w_addr[IDX_W+1:2];
    assign w_oor   = w_addr[ADDR_WIDTH-1:2] >= (ADDR_WIDTH-2)'(DEPTH_WORDS);
    assign w_err   = w_err_f3 || w_mis || w_oor;

    always_comb begin
        w_err_f3 = 1'b0;
        w_mis    = 1'b0;
        case (w_f3)
            3'b000:  ;
            3'b001:  w_mis = w_addr[0];
            3'b010:  w_mis = |w_addr[1:0];
            3'b100:  w_err_f3 = w_wr;
            3'b101: begin
                w_err_f3 = w_wr;
                w_mis    = w_addr[0];
            end
            default: w_err_f3 = 1'b1;
        endcase
    end

    always_comb begin
        w_strb      = 4'b1111;
        w_wdata_rep = w_wdata;
        case (w_f3[1:0])
            2'b00: begin
                w_strb      = 4'b0001 << w_lane;
                w_wdata_rep = {4{w_wdata[7:0]}};
            end
            2'b01: begin
                w_strb      = 4'b0011 << w_lane;
                w_wdata_rep = {2{w_wdata[15:0]}};
            end
            default: ;
        endcase
    end

    assign w_rword = r_mem[w_idx];
    assign w_byte  = w_rword[{w_lane, 3'b000} +: 8];
    assign w_half  = w_rword[{w_lane[1], 4'b0000} +: 16];

    always_comb begin
        case (w_f3)
            3'b000:  w_ext = {{24{w_byte[7]}}, w_byte};
            3'b100:  w_ext = {24'd0, w_byte};
            3'b001:  w_ext = {{16{w_half[15]}}, w_half};
            3'b101:  w_ext = {16'd0, w_half};
            default: w_ext = w_rword;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (w_enter_resp && w_wr && !w_err) begin
            for (int unsigned b = 0; b < 4; b++) begin
                if (w_strb[b]) r_mem[w_idx][8*b +: 8] <= w_wdata_rep[8*b +: 8];
            end
        end
    end

    always_ff @(posedge Clk or negedge ResetN) begin
        if (!ResetN) begin
            r_rdata <= '0;
            r_err   <= 1'b0;
        end else if (w_enter_resp) begin
            r_rdata <= (!w_wr && !w_err) ? w_ext : '0;
            r_err   <= w_err;
        end
    end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: a WAIT_CYCLES=2 and a WAIT_CYCLES=0 instance,
// expected responses from a byte-level memory model queued at issue time.
module tb_dmem_responder;
    localparam int DEPTH = 512;

    logic Clk = 1'b0;
    logic ResetN = 1'b0;
    always #5 Clk = ~Clk;

    dmem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifw ();
    dmem_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) ifz ();

    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2))
        u_dut_w2 (.Clk(Clk), .ResetN(ResetN), .bus(ifw));
    dmem_responder #(.DATA_WIDTH(32), .ADDR_WIDTH(32), .DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0))
        u_dut_w0 (.Clk(Clk), .ResetN(ResetN), .bus(ifz));

    bit          sel = 1'b0;
    logic        req_valid = 1'b0, req_wr = 1'b0, rsp_ready = 1'b0;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic [2:0]  req_f3 = '0;

    assign ifw.ReqValid  = req_valid & ~sel;
    assign ifw.ReqWr     = req_wr;
    assign ifw.ReqAddr   = req_addr;
    assign ifw.ReqFunct3 = req_f3;
    assign ifw.ReqWrData = req_wdata;
    assign ifw.RspReady  = rsp_ready & ~sel;
    assign ifz.ReqValid  = req_valid & sel;
    assign ifz.ReqWr     = req_wr;
    assign ifz.ReqAddr   = req_addr;
    assign ifz.ReqFunct3 = req_f3;
    assign ifz.ReqWrData = req_wdata;
    assign ifz.RspReady  = rsp_ready & sel;

    logic        rq, rv, re;
    logic [31:0] rd;
    assign rq = sel ? ifz.ReqReady  : ifw.ReqReady;
    assign rv = sel ? ifz.RspValid  : ifw.RspValid;
    assign re = sel ? ifz.RspErr    : ifw.RspErr;
    assign rd = sel ? ifz.RspRdData : ifw.RspRdData;

    logic [7:0]  mdl [2][DEPTH*4];
    logic [32:0] sb [$];
    int          nvec = 0, nerr = 0;
    time         t_acc = 0, t_prev = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model(input bit wr, input logic [31:0] a, input logic [2:0] f3,
                         input logic [31:0] wd, output logic [31:0] erd, output logic eerr);
        int unsigned n = 1;
        bit sgn = 1'b0, ok = 1'b1;
        case (f3)
            3'd0: sgn = 1'b1;
            3'd1: begin n = 2; sgn = 1'b1; end
            3'd2: n = 4;
            3'd4: ok = !wr;
            3'd5: begin n = 2; ok = !wr; end
            default: ok = 1'b0;
        endcase
        eerr = !ok || (a % n != 0) || (a >= DEPTH * 4);
        erd  = '0;
        if (!eerr) begin
            for (int unsigned b = 0; b < n; b++) begin
                if (wr) mdl[sel][a + b] = wd[8*b +: 8];
                else    erd[8*b +: 8] = mdl[sel][a + b];
            end
            if (!wr && sgn && erd[8*n - 1])
                for (int unsigned b = n; b < 4; b++) erd[8*b +: 8] = 8'hFF;
        end
    endtask

    task automatic do_req(input bit wr, input logic [31:0] a, input logic [2:0] f3,
                          input logic [31:0] wd, input int hold, input string tag);
        logic [31:0] erd, held;
        logic        eerr;
        logic [32:0] e;
        int          k;
        model(wr, a, f3, wd, erd, eerr);
        sb.push_back({eerr, erd});
        req_valid = 1'b1; req_wr = wr; req_addr = a; req_f3 = f3; req_wdata = wd;
        rsp_ready = 1'b0;
        k = 0;
        @(negedge Clk);
        while (!rq && k < 50) begin @(negedge Clk); k++; end
        chk({tag, " accept"}, {31'd0, rq}, 32'd1);
        @(posedge Clk);
        t_prev = t_acc;
        t_acc  = $time;
        #1 req_valid = 1'b0;
        k = 1;
        while (!rv && k < 50) begin @(posedge Clk); #1; k++; end
        chk({tag, " latency"}, k, sel ? 32'd1 : 32'd3);
        held = rd;
        repeat (hold) begin
            @(posedge Clk); #1;
            chk({tag, " hold data"}, rd, held);
            chk({tag, " hold rv/rq"}, {30'd0, rv, rq}, 32'b10);
        end
        e = sb.pop_front();
        chk({tag, " rdata"}, rd, e[31:0]);
        chk({tag, " err"}, {31'd0, re}, {31'd0, e[32]});
        rsp_ready = 1'b1;
        @(posedge Clk); #1 rsp_ready = 1'b0;
        chk({tag, " idle"}, {30'd0, rv, rq}, 32'b01);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        #3;
        chk("rst rv/rq/err", {29'd0, ifw.RspValid, ifw.ReqReady, ifw.RspErr}, 32'd0);
        chk("rst rdata", ifw.RspRdData, 32'd0);
        @(negedge Clk); @(negedge Clk);
        ResetN = 1'b1;
        #1 chk("rstdone before edge", {31'd0, ifw.ReqReady}, 32'd0);
        @(posedge Clk); #1;
        chk("rstdone after edge", {31'd0, ifw.ReqReady}, 32'd1);

        do_req(1, 32'h0, 3'd2, 32'h8070_F0FF, 0, "sw preload");
        do_req(0, 32'h1, 3'd0, 32'h0, 0, "lb @1");
        do_req(0, 32'h1, 3'd4, 32'h0, 0, "lbu @1");
        do_req(0, 32'h2, 3'd1, 32'h0, 0, "lh @2");
        do_req(0, 32'h0, 3'd5, 32'h0, 0, "lhu @0");
        do_req(1, 32'h4, 3'd2, 32'h1122_3344, 0, "sw @4");
        do_req(1, 32'h6, 3'd1, 32'h0000_BEEF, 0, "sh @6");
        do_req(0, 32'h4, 3'd2, 32'h0, 0, "lw @4");
        do_req(1, 32'h3, 3'd0, 32'h0000_005A, 0, "sb @3");
        do_req(0, 32'h0, 3'd2, 32'h0, 0, "lw @0");
        do_req(0, 32'h2, 3'd2, 32'h0, 0, "lw mis");
        do_req(1, 32'h5, 3'd1, 32'h0000_FFFF, 0, "sh mis");
        do_req(0, 32'h4, 3'd2, 32'h0, 0, "lw after sh mis");
        do_req(0, DEPTH * 4, 3'd2, 32'h0, 0, "lw oor");
        do_req(0, 32'h0, 3'd3, 32'h0, 0, "load f3=011");
        do_req(1, 32'h0, 3'd4, 32'hFFFF_FFFF, 0, "store f3=100");
        do_req(0, 32'h0, 3'd2, 32'h0, 5, "backpressure");
        do_req(0, 32'h4, 3'd1, 32'h0, 0, "b2b a");
        do_req(0, 32'h6, 3'd0, 32'h0, 0, "b2b b");
        chk("b2b period w2", 32'(t_acc - t_prev), 32'd40);

        do_req(1, 32'h8, 3'd2, 32'hCAFE_F00D, 0, "sw @8 old");
        req_valid = 1'b1; req_wr = 1'b1; req_addr = 32'h8; req_f3 = 3'd2;
        req_wdata = 32'h1234_5678;
        @(negedge Clk);
        chk("inflight accept", {31'd0, rq}, 32'd1);
        @(posedge Clk); #1 req_valid = 1'b0;
        @(posedge Clk); #1 ResetN = 1'b0;
        #1 chk("inflight reset rv/rq", {30'd0, rv, rq}, 32'd0);
        @(negedge Clk); @(negedge Clk);
        ResetN = 1'b1;
        @(posedge Clk); #1;
        chk("post reset ready", {31'd0, rq}, 32'd1);
        do_req(0, 32'h8, 3'd2, 32'h0, 0, "lw @8 old");

        sel = 1'b1;
        do_req(1, 32'h10, 3'd2, 32'hA5C3_9601, 0, "w0 sw");
        do_req(0, 32'h10, 3'd2, 32'h0, 0, "w0 lw");
        chk("b2b period w0", 32'(t_acc - t_prev), 32'd20);
        do_req(0, 32'h12, 3'd1, 32'h0, 0, "w0 lh");
        do_req(1, 32'h11, 3'd0, 32'h0000_0080, 0, "w0 sb");
        do_req(0, 32'h11, 3'd0, 32'h0, 0, "w0 lb");
        do_req(0, 32'h10, 3'd2, 32'h0, 2, "w0 lw hold");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
